mem_stage_sbuf: RTL and testbench

Parametrised memory-access stage for the five-stage MIPS pipeline. It replaces the direct-store memory stage with a DEPTH-entry coalescing store buffer in front of the data memory array. The buffer drains one entry per cycle into memory, and loads see the merged buffer and memory view. The stage sits between the EX/MEM and MEM/WB pipeline registers and raises `stall` to the hazard unit when it cannot accept a store or a fence.

---
 rtl/mem_stage_sbuf_pkg.sv | 61 ++++++
 rtl/mem_stage_sbuf_mem_array.sv | 35 +++
 rtl/mem_stage_sbuf.sv | 163 ++++++++++++++++
 tb/tb_mem_stage_sbuf.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_sbuf_pkg.sv
// Shared definitions for the coalescing store-buffer memory stage:
// access-mode encodings plus byte-enable, lane-placement and load-extract helpers.
package mem_stage_sbuf_pkg;

  localparam logic [1:0] MODE_W   = 2'b00;
  localparam logic [1:0] MODE_H   = 2'b01;
  localparam logic [1:0] MODE_B   = 2'b10;
  localparam int         SEXT_BIT = 2;

  // Byte enables of a store within its word, from access size and byte offset.
  function automatic logic [3:0] byte_en(input logic [1:0] mode, input logic [1:0] off);
    logic [3:0] be;
    case (mode)
      MODE_B:  be = 4'b0001 << off;
      MODE_H:  be = off[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate sub-word store data across lanes; byte enables select the live copy.
  function automatic logic [31:0] lane_shift(input logic [1:0] mode, input logic [31:0] data);
    logic [31:0] d;
    case (mode)
      MODE_B:  d = {4{data[7:0]}};
      MODE_H:  d = {2{data[15:0]}};
      default: d = data;
    endcase
    return d;
  endfunction

  // Alignment violation for the given access size.
  function automatic logic misaligned(input logic [1:0] mode, input logic [1:0] off);
    logic m;
    case (mode)
      MODE_B:  m = 1'b0;
      MODE_H:  m = off[0];
      default: m = (off != 2'b00);
    endcase
    return m;
  endfunction

  // Pull the addressed byte/half/word out of a merged word and extend it.
  function automatic logic [31:0] load_extract(input logic [2:0] mode, input logic [1:0] off,
                                               input logic [31:0] word);
    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    shifted = word >> {off, 3'b000};
    b       = shifted[7:0];
    h       = off[1] ? word[31:16] : word[15:0];
    case (mode[1:0])
      MODE_B:  res = mode[SEXT_BIT] ? {{24{b[7]}}, b} : {24'h000000, b};
      MODE_H:  res = mode[SEXT_BIT] ? {{16{h[15]}}, h} : {16'h0000, h};
      default: res = word;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_stage_sbuf_mem_array.sv
// Data memory: MEM_WORDS x 32, byte-enabled synchronous write,
// asynchronous read, asynchronous clear to zero.
module sbuf_mem_array #(
  parameter int MEM_WORDS = 1024
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_we,
  input  logic [$clog2(MEM_WORDS)-1:0] i_waddr,
  input  logic [3:0]                   i_be,
  input  logic [31:0]                  i_wdata,
  input  logic [$clog2(MEM_WORDS)-1:0] i_raddr,
  output logic [31:0]                  o_rdata
);

  logic [31:0] r_mem [MEM_WORDS];

  // Clear every word on reset; otherwise write enabled byte lanes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_WORDS; i++) begin
        r_mem[i] <= 32'h0000_0000;
      end
    end else if (i_we) begin
      for (int l = 0; l < 4; l++) begin
        if (i_be[l]) begin
          r_mem[i_waddr][8*l +: 8] <= i_wdata[8*l +: 8];
        end
      end
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mem_stage_sbuf.sv
// MEM stage with a DEPTH-entry coalescing store buffer in front of the data
// memory. One entry drains per cycle; loads see the merged buffer+memory view.
module mem_stage_sbuf
  import mem_stage_sbuf_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int MEM_WORDS = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     valid,
  input  logic                     mem_write,
  input  logic                     mem_read,
  input  logic [2:0]               mem_mode,
  input  logic                     fence,
  input  logic [31:0]              addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata,
  output logic                     stall,
  output logic                     addr_err,
  output logic [$clog2(DEPTH):0]   sb_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int AW = $clog2(MEM_WORDS);

  // Buffer storage, kept in age order between head and tail.
  logic [AW-1:0] r_addr [DEPTH];
  logic [3:0]    r_be   [DEPTH];
  logic [31:0]   r_data [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic [1:0]    w_mode;
  logic [1:0]    w_off;
  logic [29:0]   w_word;
  logic [AW-1:0] w_waddr;
  logic          w_oor;
  logic          w_access;
  logic          w_empty;
  logic          w_full;
  logic          w_drain;
  logic [PW-1:0] w_newest;
  logic          w_coal_ok;
  logic          w_stall_st;
  logic          w_stall_fn;
  logic          w_accept;
  logic          w_alloc;
  logic          w_coal;
  logic [3:0]    w_st_be;
  logic [31:0]   w_st_data;
  logic [31:0]   w_mem_rdata;
  logic [31:0]   w_merged;
  logic [PW-1:0] w_idx;
  logic          w_hit;

  assign w_mode   = mem_mode[1:0];
  assign w_off    = addr[1:0];
  assign w_word   = addr[31:2];
  assign w_waddr  = addr[AW+1:2];
  assign w_oor    = (w_word >= 30'(MEM_WORDS));
  assign w_access = valid & (mem_read | mem_write);
  assign addr_err = w_access & (misaligned(w_mode, w_off) | w_oor);

  assign w_empty  = (r_count == CW'(0));
  assign w_full   = (r_count == CW'(DEPTH));
  assign w_drain  = !w_empty;
  assign w_newest = r_tail - PW'(1);

  // Only the newest entry may absorb a store, and never while it is the draining head.
  assign w_coal_ok = !w_empty && !addr_err && r_vld[w_newest] &&
                     (r_addr[w_newest] == w_waddr) &&
                     !(w_drain && (w_newest == r_head));

  assign w_stall_st = valid & mem_write & w_full & !w_coal_ok;
  assign w_stall_fn = valid & fence & !w_empty;
  assign stall      = w_stall_st | w_stall_fn;

  assign w_accept = valid & mem_write & !addr_err & !stall;
  assign w_alloc  = w_accept & !w_coal_ok;
  assign w_coal   = w_accept & w_coal_ok;

  assign w_st_be   = byte_en(w_mode, w_off);
  assign w_st_data = lane_shift(w_mode, wdata);

  assign sb_count = r_count;

  sbuf_mem_array #(
    .MEM_WORDS (MEM_WORDS)
  ) u_mem (
    .clk     (clk),
    .rst_n   (reset),
    .i_we    (w_drain),
    .i_waddr (r_addr[r_head]),
    .i_be    (r_be[r_head]),
    .i_wdata (r_data[r_head]),
    .i_raddr (w_waddr),
    .o_rdata (w_mem_rdata)
  );

  // Per-lane youngest match: walk oldest to youngest so later hits override earlier ones.
  always_comb begin
    w_merged = w_mem_rdata;
    w_idx    = r_head;
    w_hit    = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_head + PW'(i);
      w_hit = r_vld[w_idx] && (r_addr[w_idx] == w_waddr);
      for (int l = 0; l < 4; l++) begin
        w_merged[8*l +: 8] = (w_hit && r_be[w_idx][l]) ? r_data[w_idx][8*l +: 8]
                                                       : w_merged[8*l +: 8];
      end
    end
  end

  assign rdata = (valid & mem_read & !addr_err) ? load_extract(mem_mode, w_off, w_merged)
                                                : 32'h0000_0000;

  // Buffer state: drain head every non-empty cycle, merge or allocate accepted stores.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_be[i]   <= 4'b0000;
        r_data[i] <= 32'h0000_0000;
      end
      r_vld   <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_drain) begin
        r_vld[r_head] <= 1'b0;
        r_head        <= r_head + PW'(1);
      end
      if (w_coal) begin
        for (int l = 0; l < 4; l++) begin
          if (w_st_be[l]) begin
            r_data[w_newest][8*l +: 8] <= w_st_data[8*l +: 8];
          end
        end
        r_be[w_newest] <= r_be[w_newest] | w_st_be;
      end
      if (w_alloc) begin
        r_addr[r_tail] <= w_waddr;
        r_be[r_tail]   <= w_st_be;
        r_data[r_tail] <= w_st_data & {{8{w_st_be[3]}}, {8{w_st_be[2]}},
                                       {8{w_st_be[1]}}, {8{w_st_be[0]}}};
        r_vld[r_tail]  <= 1'b1;
        r_tail         <= r_tail + PW'(1);
      end
      case ({w_alloc, w_drain})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_sbuf.sv
// Self-checking bench for mem_stage_sbuf: directed scenarios followed by
// random traffic, all checked against a byte-level queue model.
module tb_mem_stage_sbuf;

  localparam int DEPTH     = 4;
  localparam int MEM_WORDS = 1024;

  localparam logic [2:0] M_W   = 3'b000;
  localparam logic [2:0] M_HU  = 3'b001;
  localparam logic [2:0] M_BU  = 3'b010;
  localparam logic [2:0] M_HS  = 3'b101;
  localparam logic [2:0] M_BS  = 3'b110;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid, mem_write, mem_read, fence;
  logic [2:0]  mem_mode;
  logic [31:0] addr, wdata, rdata;
  logic        stall, addr_err;
  logic [$clog2(DEPTH):0] sb_count;

  always #5 clk = ~clk;

  mem_stage_sbuf #(.DEPTH(DEPTH), .MEM_WORDS(MEM_WORDS)) u_dut (
    .clk(clk), .reset(reset), .valid(valid), .mem_write(mem_write),
    .mem_read(mem_read), .mem_mode(mem_mode), .fence(fence), .addr(addr),
    .wdata(wdata), .rdata(rdata), .stall(stall), .addr_err(addr_err),
    .sb_count(sb_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int unsigned waddr;
    logic [3:0]  be;
    logic [31:0] data;
  } ent_t;

  ent_t       q[$];
  logic [7:0] mem_b [4*MEM_WORDS];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int sz(input logic [2:0] m);
    if (m[1:0] == 2'b10) return 1;
    if (m[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit m_err(input bit v, input bit w, input bit r,
                               input logic [2:0] m, input logic [31:0] a);
    if (!(v && (w || r))) return 1'b0;
    return ((a % sz(m)) != 0) || ((a / 4) >= MEM_WORDS);
  endfunction

  function automatic logic [7:0] view_byte(input int unsigned ba);
    logic [7:0] b;
    b = mem_b[ba];
    foreach (q[i]) begin
      if (q[i].waddr == ba / 4 && q[i].be[ba % 4]) b = q[i].data[8*(ba % 4) +: 8];
    end
    return b;
  endfunction

  function automatic logic [31:0] m_rdata(input bit v, input bit r, input bit err,
                                          input logic [2:0] m, input logic [31:0] a);
    logic [31:0] val;
    int n;
    if (!(v && r) || err) return 32'h0;
    n   = sz(m);
    val = 32'h0;
    for (int k = 0; k < n; k++) val = val | (32'(view_byte(a + k)) << (8 * k));
    if (m[2] && n < 4 && val[8*n-1]) val = val | ~((32'h1 << (8 * n)) - 32'h1);
    return val;
  endfunction

  task automatic model_clear();
    q.delete();
    for (int i = 0; i < 4*MEM_WORDS; i++) mem_b[i] = 8'h00;
  endtask

  // One pipeline cycle: drive at negedge, check mid-cycle, update the model at posedge.
  task automatic step(input string tag, input bit v, input bit w, input bit r, input bit f,
                      input logic [2:0] m, input logic [31:0] a, input logic [31:0] d);
    bit   e_err, e_coal, e_stall;
    ent_t e, t;
    valid = v; mem_write = w; mem_read = r; fence = f; mem_mode = m; addr = a; wdata = d;
    #1;
    e_err   = m_err(v, w, r, m, a);
    e_coal  = !e_err && q.size() >= 2 && q[q.size()-1].waddr == a / 4;
    e_stall = (v && w && q.size() == DEPTH && !e_coal) || (v && f && q.size() != 0);
    chk({tag, ".err"},   32'(addr_err), 32'(e_err));
    chk({tag, ".stall"}, 32'(stall),    32'(e_stall));
    chk({tag, ".rdata"}, rdata,         m_rdata(v, r, e_err, m, a));
    chk({tag, ".count"}, 32'(sb_count), 32'(q.size()));
    @(posedge clk);
    if (q.size() > 0) begin
      e = q.pop_front();
      for (int l = 0; l < 4; l++) if (e.be[l]) mem_b[e.waddr*4 + l] = e.data[8*l +: 8];
    end
    if (v && w && !e_err && !e_stall) begin
      e.waddr = a / 4; e.be = 4'b0000; e.data = 32'h0;
      for (int k = 0; k < sz(m); k++) begin
        e.be[(a % 4) + k] = 1'b1;
        e.data[8*((a % 4) + k) +: 8] = d[8*k +: 8];
      end
      if (e_coal) begin
        t = q.pop_back();
        for (int l = 0; l < 4; l++) if (e.be[l]) t.data[8*l +: 8] = e.data[8*l +: 8];
        t.be = t.be | e.be;
        q.push_back(t);
      end else begin
        q.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step("idle", 1'b0, 1'b0, 1'b0, 1'b0, M_W, 32'h0, 32'h0);
  endtask

  initial begin
    int unsigned op, a, mm;
    reset = 1'b0; valid = 1'b0; mem_write = 1'b0; mem_read = 1'b0; fence = 1'b0;
    mem_mode = M_W; addr = 32'h0; wdata = 32'h0;
    model_clear();
    @(negedge clk);
    #1;
    chk("rst.count", 32'(sb_count), 32'h0);
    chk("rst.stall", 32'(stall),    32'h0);
    chk("rst.rdata", rdata,         32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Word store then load from the buffer, then from memory after drain.
    step("sw10",  1, 1, 0, 0, M_W, 32'h10, 32'h1234_5678);
    step("lw10",  1, 0, 1, 0, M_W, 32'h10, 32'h0);
    idle(2);
    step("lw10m", 1, 0, 1, 0, M_W, 32'h10, 32'h0);

    // Byte merge and extension.
    step("sw20",  1, 1, 0, 0, M_W,  32'h20, 32'h0);
    step("sb21",  1, 1, 0, 0, M_BU, 32'h21, 32'h0000_0080);
    step("sh22",  1, 1, 0, 0, M_HU, 32'h22, 32'h0000_BEEF);
    step("lw20",  1, 0, 1, 0, M_W,  32'h20, 32'h0);
    step("lb21",  1, 0, 1, 0, M_BS, 32'h21, 32'h0);
    step("lhu22", 1, 0, 1, 0, M_HU, 32'h22, 32'h0);
    step("lh22",  1, 0, 1, 0, M_HS, 32'h22, 32'h0);
    step("lbu23", 1, 0, 1, 0, M_BU, 32'h23, 32'h0);

    // Back-to-back stores to distinct words, then read them all back.
    for (int i = 0; i < 5; i++) step("full", 1, 1, 0, 0, M_W, 32'h40 + 32'(4*i), 32'hA000_0000 + 32'(i));
    idle(DEPTH);
    for (int i = 0; i < 5; i++) step("fullrd", 1, 0, 1, 0, M_W, 32'h40 + 32'(4*i), 32'h0);

    // Fence after stores.
    for (int i = 0; i < 3; i++) step("fst", 1, 1, 0, 0, M_W, 32'h80 + 32'(4*i), 32'h5A5A_0000 + 32'(i));
    for (int i = 0; i < 3; i++) step("fence", 1, 0, 0, 1, M_W, 32'h0, 32'h0);

    // Misaligned and out-of-range accesses.
    step("sh31",   1, 1, 0, 0, M_HU, 32'h31, 32'h0000_1111);
    step("lw32",   1, 0, 1, 0, M_W,  32'h32, 32'h0);
    step("lh30",   1, 0, 1, 0, M_HU, 32'h30, 32'h0);
    step("swoor",  1, 1, 0, 0, M_W,  32'h1000, 32'hDEAD_BEEF);
    step("lwoor",  1, 0, 1, 0, M_W,  32'h1000, 32'h0);
    step("lw0",    1, 0, 1, 0, M_W,  32'h0, 32'h0);

    // Reset between edges while stores are pending.
    for (int i = 0; i < 3; i++) step("rst_st", 1, 1, 0, 0, M_W, 32'hC0 + 32'(4*i), 32'h7777_0000 + 32'(i));
    valid = 1'b1; fence = 1'b1; mem_write = 1'b0; mem_read = 1'b0;
    #2 reset = 1'b0;
    #1;
    model_clear();
    chk("midrst.count", 32'(sb_count), 32'h0);
    chk("midrst.stall", 32'(stall),    32'h0);
    valid = 1'b0; fence = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) step("rst_ld", 1, 0, 1, 0, M_W, 32'hC0 + 32'(4*i), 32'h0);
    step("rst_ld10", 1, 0, 1, 0, M_W, 32'h10, 32'h0);

    // Random traffic over a small window of words, with occasional bad addresses.
    for (int i = 0; i < 400; i++) begin
      op = $urandom_range(0, 4);
      mm = $urandom_range(0, 2);
      a  = ($urandom_range(0, 15) * 4) + $urandom_range(0, 3);
      if ($urandom_range(0, 19) == 0) a = a + 32'h0000_1000;
      step("rnd", ($urandom_range(0, 9) != 0), (op == 0 || op == 4), (op == 1),
           (op == 2), {1'($urandom_range(0, 1)), 2'(mm)}, 32'(a), $urandom());
    end
    idle(DEPTH + 1);

    // Final memory image against the model.
    for (int i = 0; i < MEM_WORDS; i++) begin
      chk("memimg", u_dut.u_mem.r_mem[i],
          {mem_b[4*i+3], mem_b[4*i+2], mem_b[4*i+1], mem_b[4*i]});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
